// File: rtl/mips_pkg.sv
// Shared fetch/stall definitions: opcodes, reset instruction word, fetch FSM encoding.
package mips_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned WORD_W   = 32;

    localparam logic [OP_W-1:0]   OP_HLT      = 6'b010001;
    localparam logic [OP_W-1:0]   OP_LD       = 6'b010100;
    localparam logic [3:0]        OP_JUMP_HI  = 4'b0111;
    localparam logic [WORD_W-1:0] NOP_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Jump-class opcodes share the upper four opcode bits.
    function automatic logic is_jump_op(input logic [OP_W-1:0] op);
        return op[5:2] == OP_JUMP_HI;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: stall/jump controls and program-memory data in, fetch results out.
//   master : the fetch unit (drives pm_addr, instr, op, instr_valid, pc_plus1, halted)
//   slave  : stall control / decode / program memory side
interface instruction_fetch_unit_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned IW = 32
);
    logic          stall;
    logic          stall_pm;
    logic          jump_en;
    logic [AW-1:0] jump_target;
    logic [IW-1:0] pm_rdata;
    logic [AW-1:0] pm_addr;
    logic [IW-1:0] instr;
    logic [5:0]    op;
    logic          instr_valid;
    logic [AW-1:0] pc_plus1;
    logic          halted;

    modport master (
        input  stall, stall_pm, jump_en, jump_target, pm_rdata,
        output pm_addr, instr, op, instr_valid, pc_plus1, halted
    );

    modport slave (
        output stall, stall_pm, jump_en, jump_target, pm_rdata,
        input  pm_addr, instr, op, instr_valid, pc_plus1, halted
    );
endinterface

// File: rtl/pc_counter.sv
// Program counter: load beats hold, hold beats increment; async active-low clear.
//   i_clk, i_rst_n      clock, async active-low clear
//   i_load, i_load_val  redirect the PC
//   i_hold              freeze the PC (stall or halt)
//   o_pc                current PC
module pc_counter #(
    parameter int unsigned AW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_val,
    input  logic          i_hold,
    output logic [AW-1:0] o_pc
);
    logic [AW-1:0] r_pc;

    // Natural AW-bit wrap on increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (!i_hold) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, program-memory address, instruction register, HLT detection.
//   clk, reset   clock, async active-low reset
//   bus.master   stall/stall_pm/jump inputs, pm_rdata in; pm_addr, instr, op,
//                instr_valid, pc_plus1, halted out
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned   AW       = 8,
    parameter int unsigned   IW       = 32,
    parameter logic [IW-1:0] NOP_WORD = IW'(mips_pkg::NOP_WORD)
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_unit_if.master   bus
);
    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [IW-1:0] r_instr;
    logic          r_instr_valid;
    logic          r_halted;
    logic          w_hlt_hit;
    logic          w_pc_load;
    logic          w_pc_hold;
    logic          w_instr_load;
    logic [AW-1:0] w_pc;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle PC / instr controls. HALT overrides a same-cycle jump.
    always_comb begin
        w_state_nxt  = r_state;
        w_hlt_hit    = 1'b0;
        w_pc_load    = 1'b0;
        w_pc_hold    = 1'b1;
        w_instr_load = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                w_pc_load    = bus.jump_en;
                w_pc_hold    = bus.stall;
                w_instr_load = !bus.stall_pm;
                w_state_nxt  = ST_RUN;
            end
            ST_RUN: begin
                w_hlt_hit = r_instr_valid && !bus.stall_pm
                            && (r_instr[IW-1 -: 6] == OP_HLT);
                if (w_hlt_hit) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_pc_load    = bus.jump_en;
                    w_pc_hold    = bus.stall;
                    w_instr_load = !bus.stall_pm;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // Instruction register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            if (w_instr_load) begin
                r_instr <= bus.pm_rdata;
            end
            if (r_state == ST_BOOT) begin
                r_instr_valid <= 1'b1;
            end
            if (w_hlt_hit) begin
                r_halted <= 1'b1;
            end
        end
    end

    pc_counter #(.AW(AW)) u_pc (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_pc_load),
        .i_load_val (bus.jump_target),
        .i_hold     (w_pc_hold),
        .o_pc       (w_pc)
    );

    assign bus.pm_addr     = w_pc;
    assign bus.pc_plus1    = w_pc + AW'(1);
    assign bus.instr       = r_instr;
    assign bus.op          = r_instr[IW-1 -: 6];
    assign bus.instr_valid = r_instr_valid;
    assign bus.halted      = r_halted;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a cycle-level reference model.
module tb_instruction_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] HLT_WORD = 32'h4400_0000;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;

    instruction_fetch_unit_if #(.AW(8), .IW(32)) bus ();
    instruction_fetch_unit_if #(.AW(4), .IW(32)) bus4 ();

    instruction_fetch_unit #(.AW(8), .IW(32), .NOP_WORD(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instruction_fetch_unit #(.AW(4), .IW(32), .NOP_WORD(32'h0)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memories: one-cycle synchronous read.
    logic [31:0] mem [256];
    always @(posedge clk) bus.pm_rdata <= mem[bus.pm_addr];
    always @(posedge clk) bus4.pm_rdata <= {28'h0, bus4.pm_addr};

    // Reference state.
    logic [7:0]  m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_rdata;
    logic        m_valid;
    logic        m_halted;
    logic [3:0]  m4_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 8'h00;
        m_instr  = 32'h0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m4_pc    = 4'h0;
    endtask

    // One rising edge of the reference: fetch rules from the fetch-stage description.
    task automatic model_edge();
        logic [31:0] rd_new;
        rd_new = mem[m_pc];
        if (!reset) begin
            model_reset();
        end else begin
            if (!m_halted) begin
                if (m_valid && !bus.stall_pm && m_instr[31:26] == 6'b010001) begin
                    m_halted = 1'b1;
                end else begin
                    if (bus.jump_en)   m_pc = bus.jump_target;
                    else if (!bus.stall) m_pc = m_pc + 8'd1;
                    if (!bus.stall_pm) m_instr = m_rdata;
                    m_valid = 1'b1;
                end
            end
            m4_pc = m4_pc + 4'd1;
        end
        m_rdata = rd_new;
    endtask

    task automatic check_all();
        check("pm_addr",     64'(bus.pm_addr),     64'(m_pc));
        check("instr",       64'(bus.instr),       64'(m_instr));
        check("op",          64'(bus.op),          64'(m_instr[31:26]));
        check("instr_valid", 64'(bus.instr_valid), 64'(m_valid));
        check("pc_plus1",    64'(bus.pc_plus1),    64'(8'(m_pc + 8'd1)));
        check("halted",      64'(bus.halted),      64'(m_halted));
        check("pm_addr_aw4", 64'(bus4.pm_addr),    64'(m4_pc));
        check("pc_plus1_aw4",64'(bus4.pc_plus1),   64'(4'(m4_pc + 4'd1)));
    endtask

    // Advance one clock: model steps on the edge, outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_idle();
        bus.stall       = 1'b0;
        bus.stall_pm    = 1'b0;
        bus.jump_en     = 1'b0;
        bus.jump_target = 8'h00;
    endtask

    task automatic set_random();
        bus.stall       = ($urandom_range(0, 3) == 0);
        bus.stall_pm    = bus.stall ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
        bus.jump_en     = ($urandom_range(0, 7) == 0);
        bus.jump_target = 8'($urandom);
    endtask

    // 0: mem[i]=i, 1: random without HLT, 2: random with sparse HLT, 3: mem[i]=i with HLT at 3
    task automatic fill_mem(input int mode);
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 32'(i);
            if (mode == 1 || mode == 2) begin
                w = $urandom;
                if (w[31:26] == OP_HLT) w[26] = ~w[26];
                if (mode == 2 && $urandom_range(0, 40) == 0) w = HLT_WORD | 32'($urandom_range(0, 255));
            end
            mem[i] = w;
        end
        if (mode == 3) mem[3] = HLT_WORD;
    endtask

    // Synchronous-looking reset sequence started at a falling edge.
    task automatic do_reset(input int mode);
        set_idle();
        reset = 1'b0;
        model_reset();
        fill_mem(mode);
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    // Reset asserted between edges: outputs must clear with no clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check({tag, "_pm_addr"}, 64'(bus.pm_addr),     64'h0);
        check({tag, "_instr"},   64'(bus.instr),       64'h0);
        check({tag, "_valid"},   64'(bus.instr_valid), 64'h0);
        check({tag, "_halted"},  64'(bus.halted),      64'h0);
        check({tag, "_aw4"},     64'(bus4.pm_addr),    64'h0);
        @(negedge clk);
        set_idle();
        cycle();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        bus4.stall       = 1'b0;
        bus4.stall_pm    = 1'b0;
        bus4.jump_en     = 1'b0;
        bus4.jump_target = 4'h0;
        model_reset();
        m_rdata = 32'h0;
        fill_mem(0);
        @(negedge clk);
        check_all();

        // Free run from reset, then two stalled cycles at pc=5, then jump+stall.
        do_reset(0);
        for (int i = 0; i < 5; i++) cycle();
        check("t2_pc_before_stall", 64'(bus.pm_addr), 64'd5);
        bus.stall = 1'b1; bus.stall_pm = 1'b1;
        cycle();
        cycle();
        check("t2_pc_held", 64'(bus.pm_addr), 64'd5);
        set_idle();
        cycle();
        check("t2_pc_after", 64'(bus.pm_addr), 64'd6);
        bus.jump_en = 1'b1; bus.jump_target = 8'h40; bus.stall = 1'b1;
        cycle();
        check("t3_jump_pc", 64'(bus.pm_addr), 64'h40);
        set_idle();
        cycle();
        cycle();
        check("t3_instr", 64'(bus.instr), 64'h40);
        for (int i = 0; i < 20; i++) cycle();

        // HLT at address 3: pc frozen at 5, later stalls/jumps ignored, then async reset in HALT.
        do_reset(3);
        for (int i = 0; i < 8; i++) cycle();
        check("t4_halted", 64'(bus.halted), 64'd1);
        check("t4_pc",     64'(bus.pm_addr), 64'd5);
        check("t4_op",     64'(bus.op), 64'(OP_HLT));
        for (int i = 0; i < 10; i++) begin
            set_random();
            cycle();
        end
        check("t4_pc_frozen", 64'(bus.pm_addr), 64'd5);
        async_reset("t6_halt");
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic without HLT, then async reset in the middle of a jump.
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            set_random();
            cycle();
        end
        bus.jump_en = 1'b1; bus.jump_target = 8'h9c;
        async_reset("t6_jump");
        for (int i = 0; i < 10; i++) cycle();

        // Random traffic with sparse HLT words and periodic async resets.
        for (int r = 0; r < 6; r++) begin
            do_reset(2);
            for (int i = 0; i < 60; i++) begin
                set_random();
                cycle();
            end
            async_reset("t6_rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
